l2_noc2_sink: RTL and testbench
===============================

# l2_noc2_sink

Synchronous NoC2 receiver that terminates the L2's response channel (`noc2_valid_out` / `noc2_data_out` / `noc2_ready_out`) in standalone L2 benches and in the tile-less test harness. It accepts 64-bit flits under valid/ready, decodes the OpenPiton header, and assembles each packet into a local buffer. It then presents the whole packet to a checker or consumer through a packet-level valid/ready handshake. Malformed and misrouted packets are flagged, and consumed so the L2 never deadlocks.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 8: maximum payload flits held; buffer depth is `MAX_PAYLOAD`.
- `CNT_W`, default 16: width of the packet and error counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `my_chipid`  in  14  expected destination chip ID.
- `my_x`  in  8  expected destination X.
- `my_y`  in  8  expected destination Y.
- `noc2_valid_in`  in  1  flit valid from the L2.
- `noc2_data_in`  in  64  flit data.
- `noc2_ready_out`  out  1  flit accept.
- `throttle`  in  1  forces `noc2_ready_out` low (backpressure injection).
- `pkt_valid`  out  1  assembled packet available.
- `pkt_ready`  in  1  consumer accepts the packet.
- `pkt_hdr`  out  64  captured header flit.
- `pkt_len`  out  8  payload flit count.
- `pkt_dest_err`  out  1  header destination differs from `my_*`; valid with `pkt_valid`.
- `pkt_rd_idx`  in  `$clog2(MAX_PAYLOAD)`  payload read index.
- `pkt_rd_data`  out  64  payload flit at `pkt_rd_idx`; combinational read; 0 if idx ≥ `pkt_len`.
- `pkt_count`  out  `CNT_W`  packets delivered; wraps.
- `len_err_count`  out  `CNT_W`  oversize packets dropped; saturates.

## Operation
- Header fields (bit ranges): chipid [63:50], x [49:42], y [41:34], fbits [33:30], payload length [29:22], msg type [21:14], mshr [13:6].
- Flit accepted when `noc2_valid_in && noc2_ready_out`. `noc2_ready_out = !throttle && (state != HOLD)`.
- FSM states and transitions:
  - HDR: on accept, capture the header, set `remain = len`, and evaluate the destination check.
    - len == 0 → HOLD.
    - len > `MAX_PAYLOAD` → DROP, with `remain = len`.
    - Otherwise → PAYLOAD.
  - PAYLOAD: each accepted flit is written to `buf[wr_ptr]`; `wr_ptr++` and `remain--`. When the accepted flit has `remain == 1` → HOLD.
  - DROP: accepted flits are discarded; when `remain == 1` on accept → HDR and `len_err_count++`. No `pkt_valid` is raised for a dropped packet.
  - HOLD: `pkt_valid = 1` and the header and buffer are frozen. When `pkt_valid && pkt_ready` → HDR, `pkt_count++`, `wr_ptr = 0`.
- `pkt_dest_err` is registered at header capture and is informational only; the packet is still delivered.
- Counter widths: `remain` is 8 bits and `wr_ptr` is `$clog2(MAX_PAYLOAD)+1` bits. `pkt_count` wraps modulo 2^`CNT_W`. `len_err_count` sticks at all-ones.

## Timing
- Reset values: state = HDR. All other outputs reset to 0: `pkt_valid`, `pkt_hdr`, `pkt_len`, `pkt_dest_err`, `pkt_count`, `len_err_count`, `wr_ptr`, `remain`. `noc2_ready_out` is 1 out of reset unless `throttle` is high. Buffer contents are don't-care.
- Delivery latency: `pkt_valid` rises the cycle after the last flit is accepted (the header flit for zero-length packets).
- Inter-packet bubble: the cycle after a packet is handed over, state is HDR and ready is high. The minimum gap between packets is therefore one HOLD cycle per packet.
- A flit presented during HOLD is not accepted. The L2 holds valid and the flit is taken in the first HDR cycle.
- `throttle` takes effect combinationally in the same cycle. The packet state is preserved across any stall length.
- `rst` asserted mid-packet or in HOLD: the next cycle is HDR with empty buffers and counters cleared. Partial flits are lost; no `pkt_valid` glitch occurs.
- `pkt_rd_data` is combinational from `pkt_rd_idx` and is stable while in HOLD.

## Structure
- Package `l2_noc2_sink_pkg`: header bit-position localparams, the state enum (HDR, PAYLOAD, DROP, HOLD), and a header-field struct/typedef reused by other NoC bench blocks.
- One sub-module, `noc_flit_buffer`: a `MAX_PAYLOAD` × 64 register file with write port (en, ptr, data) and combinational read port. The FSM and counters stay in the top module.

## Test plan
- Zero-length packet, header `len=0` matching `my_*`:
  - `pkt_valid` rises the next cycle, `pkt_len = 0`, `pkt_dest_err = 0`.
  - After `pkt_ready`, `pkt_count = 1`.
- Three-flit payload (A, B, C), back-to-back valid, with `pkt_ready` held low for 5 cycles:
  - `noc2_ready_out` stays low during HOLD.
  - `pkt_rd_data[0..2]` = A, B, C; idx 3 reads 0.
- `throttle` pulsed for 4 cycles between payload flits 1 and 2 of a `len=2` packet:
  - No flit is lost or duplicated.
  - `pkt_valid` rises 1 cycle after the second flit's accept.
- Header `len=12` with `MAX_PAYLOAD=8`:
  - All 12 payload flits are accepted and dropped.
  - No `pkt_valid`; `len_err_count = 1`.
  - A following `len=1` packet is delivered correctly.
- Header with chipid = `my_chipid` + 1: packet delivered with `pkt_dest_err = 1`.
- `rst` asserted after 2 of 5 payload flits:
  - The next cycle is HDR with `pkt_count = 0` and `pkt_valid = 0`.
  - A fresh `len=1` packet is then delivered correctly.

Source files
------------

// File: rtl/l2_noc2_sink_pkg.sv
// l2_noc2_sink_pkg
//   Shared definitions for the NoC2 sink and other NoC bench blocks:
//   OpenPiton header bit positions, the header-field struct with an unpack
//   helper, and the sink FSM state encoding.
package l2_noc2_sink_pkg;

    localparam int FLIT_W = 64;

    // Header field bit positions within a 64-bit header flit
    localparam int HDR_CHIPID_HI = 63;
    localparam int HDR_CHIPID_LO = 50;
    localparam int HDR_X_HI      = 49;
    localparam int HDR_X_LO      = 42;
    localparam int HDR_Y_HI      = 41;
    localparam int HDR_Y_LO      = 34;
    localparam int HDR_FBITS_HI  = 33;
    localparam int HDR_FBITS_LO  = 30;
    localparam int HDR_LEN_HI    = 29;
    localparam int HDR_LEN_LO    = 22;
    localparam int HDR_MSG_HI    = 21;
    localparam int HDR_MSG_LO    = 14;
    localparam int HDR_MSHR_HI   = 13;
    localparam int HDR_MSHR_LO   = 6;
    localparam int HDR_RSVD_HI   = 5;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP,
        ST_HOLD
    } sink_state_e;

    // Field order mirrors the bit positions above, so the struct packs back
    // to the original 64-bit flit unchanged.
    typedef struct packed {
        logic [13:0] chipid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  fbits;
        logic [7:0]  len;
        logic [7:0]  msg_type;
        logic [7:0]  mshr;
        logic [5:0]  rsvd;
    } noc_hdr_t;

    function automatic noc_hdr_t hdr_unpack(input logic [FLIT_W-1:0] f);
        noc_hdr_t h;
        h          = '0;
        h.chipid   = f[HDR_CHIPID_HI:HDR_CHIPID_LO];
        h.x        = f[HDR_X_HI:HDR_X_LO];
        h.y        = f[HDR_Y_HI:HDR_Y_LO];
        h.fbits    = f[HDR_FBITS_HI:HDR_FBITS_LO];
        h.len      = f[HDR_LEN_HI:HDR_LEN_LO];
        h.msg_type = f[HDR_MSG_HI:HDR_MSG_LO];
        h.mshr     = f[HDR_MSHR_HI:HDR_MSHR_LO];
        h.rsvd     = f[HDR_RSVD_HI:0];
        return h;
    endfunction

endpackage

// File: rtl/l2_noc2_sink_if.sv
// l2_noc2_sink_if
//   Flit channel (L2 -> sink) plus packet channel (sink -> consumer).
//   master : the L2 / consumer side (bench)
//   slave  : the sink
//   noc2_valid_in/noc2_data_in/noc2_ready_out : flit valid/ready handshake
//   throttle      : forces noc2_ready_out low
//   pkt_valid/pkt_ready : packet-level handshake
//   pkt_hdr/pkt_len/pkt_dest_err : captured header, payload length, dest flag
//   pkt_rd_idx/pkt_rd_data       : combinational payload read port
interface l2_noc2_sink_if #(
    parameter int MAX_PAYLOAD = 8
);
    import l2_noc2_sink_pkg::*;

    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    logic              noc2_valid_in;
    logic [FLIT_W-1:0] noc2_data_in;
    logic              noc2_ready_out;
    logic              throttle;

    logic              pkt_valid;
    logic              pkt_ready;
    logic [FLIT_W-1:0] pkt_hdr;
    logic [7:0]        pkt_len;
    logic              pkt_dest_err;
    logic [IDX_W-1:0]  pkt_rd_idx;
    logic [FLIT_W-1:0] pkt_rd_data;

    modport master (
        output noc2_valid_in, noc2_data_in, throttle, pkt_ready, pkt_rd_idx,
        input  noc2_ready_out, pkt_valid, pkt_hdr, pkt_len, pkt_dest_err,
               pkt_rd_data
    );

    modport slave (
        input  noc2_valid_in, noc2_data_in, throttle, pkt_ready, pkt_rd_idx,
        output noc2_ready_out, pkt_valid, pkt_hdr, pkt_len, pkt_dest_err,
               pkt_rd_data
    );

endinterface

// File: rtl/noc_flit_buffer.sv
// noc_flit_buffer
//   DEPTH x 64 payload register file, one write port and one combinational
//   read port. Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_ptr  : write address, one bit wider than the index so a full count
//             can be passed straight in; out-of-range writes are ignored
//   wr_data : write data
//   rd_idx  : read address
//   rd_data : read data (0 for out-of-range index)
module noc_flit_buffer
    import l2_noc2_sink_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W:0]    wr_ptr,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [FLIT_W-1:0] rd_data
);

    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0][FLIT_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr < DEPTH_W)) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < DEPTH_W) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/l2_noc2_sink.sv
// l2_noc2_sink
//   Terminates the L2 NoC2 response channel: accepts flits, decodes the
//   header, assembles the payload into a local buffer, and presents the whole
//   packet through a packet-level valid/ready handshake. Oversize packets are
//   swallowed and counted; misrouted packets are flagged but still delivered.
//   clk, rst        : clock, synchronous active-high reset
//   my_chipid/x/y   : expected destination
//   bus (slave)     : flit channel + packet channel, see l2_noc2_sink_if
//   pkt_count       : packets delivered (wraps)
//   len_err_count   : oversize packets dropped (saturates)
//   MAX_PAYLOAD must be below 256 so it fits the 8-bit header length field.
module l2_noc2_sink
    import l2_noc2_sink_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       my_chipid,
    input  logic [7:0]        my_x,
    input  logic [7:0]        my_y,
    l2_noc2_sink_if.slave     bus,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  len_err_count
);

    localparam int         IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    sink_state_e    state;
    noc_hdr_t       hdr_q;
    noc_hdr_t       in_hdr;
    logic [7:0]     remain;
    logic [IDX_W:0] wr_ptr;
    logic           pkt_valid_q;
    logic           dest_err_q;
    logic           flit_acc;
    logic           dest_mismatch;
    logic           buf_wr_en;
    logic [FLIT_W-1:0] buf_rd_data;

    assign in_hdr        = hdr_unpack(bus.noc2_data_in);
    assign dest_mismatch = (in_hdr.chipid != my_chipid) ||
                           (in_hdr.x != my_x) || (in_hdr.y != my_y);

    assign bus.noc2_ready_out = !bus.throttle && (state != ST_HOLD);
    assign flit_acc           = bus.noc2_valid_in && bus.noc2_ready_out;
    assign buf_wr_en          = flit_acc && (state == ST_PAYLOAD);

    assign bus.pkt_valid    = pkt_valid_q;
    assign bus.pkt_hdr      = hdr_q;
    assign bus.pkt_len      = hdr_q.len;
    assign bus.pkt_dest_err = dest_err_q;

    // Entries past the current packet length read as zero so stale data from
    // an earlier, longer packet never leaks to the consumer.
    assign bus.pkt_rd_data = (8'(bus.pkt_rd_idx) < hdr_q.len) ? buf_rd_data : '0;

    noc_flit_buffer #(
        .DEPTH (MAX_PAYLOAD),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (bus.noc2_data_in),
        .rd_idx  (bus.pkt_rd_idx),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_HDR;
            hdr_q         <= '0;
            remain        <= '0;
            wr_ptr        <= '0;
            pkt_valid_q   <= 1'b0;
            dest_err_q    <= 1'b0;
            pkt_count     <= '0;
            len_err_count <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (flit_acc) begin
                        hdr_q      <= in_hdr;
                        remain     <= in_hdr.len;
                        dest_err_q <= dest_mismatch;
                        wr_ptr     <= '0;
                        if (in_hdr.len == 8'd0) begin
                            state       <= ST_HOLD;
                            pkt_valid_q <= 1'b1;
                        end else if (in_hdr.len > MAX_LEN) begin
                            state <= ST_DROP;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (flit_acc) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            state       <= ST_HOLD;
                            pkt_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (flit_acc) begin
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            state <= ST_HDR;
                            if (len_err_count != {CNT_W{1'b1}}) begin
                                len_err_count <= len_err_count + 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.pkt_ready) begin
                        state       <= ST_HDR;
                        pkt_valid_q <= 1'b0;
                        pkt_count   <= pkt_count + 1'b1;
                        wr_ptr      <= '0;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_noc2_sink.sv
// tb_l2_noc2_sink
//   Directed bench for l2_noc2_sink. Inputs change on the falling edge and
//   outputs are checked on the falling edge (plus small offsets for the
//   combinational read port), well away from the rising edge.
module tb_l2_noc2_sink;
    import l2_noc2_sink_pkg::*;

    localparam int MAXP  = 8;
    localparam int CNT_W = 16;

    localparam logic [13:0] MY_CHIP = 14'h0123;
    localparam logic [7:0]  MY_X    = 8'h02;
    localparam logic [7:0]  MY_Y    = 8'h03;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] len_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    l2_noc2_sink_if #(.MAX_PAYLOAD(MAXP)) bus ();

    l2_noc2_sink #(.MAX_PAYLOAD(MAXP), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .my_chipid     (MY_CHIP),
        .my_x          (MY_X),
        .my_y          (MY_Y),
        .bus           (bus),
        .pkt_count     (pkt_count),
        .len_err_count (len_err_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [13:0] chip, input logic [7:0] len,
                                           input logic [7:0] mshr);
        return {chip, MY_X, MY_Y, 4'h0, len, 8'h5a, mshr, 6'h00};
    endfunction

    // Present one flit and return on the falling edge after it is accepted.
    task automatic send_flit(input logic [63:0] d);
        int n;
        n = 0;
        bus.noc2_valid_in = 1'b1;
        bus.noc2_data_in  = d;
        #1;
        while (!bus.noc2_ready_out && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
        @(negedge clk);
        bus.noc2_valid_in = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [63:0] exp);
        bus.pkt_rd_idx = 3'(idx);
        #1;
        chk(tag, bus.pkt_rd_data, exp);
    endtask

    task automatic consume();
        bus.pkt_ready = 1'b1;
        @(negedge clk);
        bus.pkt_ready = 1'b0;
    endtask

    logic [63:0] h;

    initial begin
        rst               = 1'b1;
        bus.noc2_valid_in = 1'b0;
        bus.noc2_data_in  = '0;
        bus.throttle      = 1'b0;
        bus.pkt_ready     = 1'b0;
        bus.pkt_rd_idx    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", 64'(bus.pkt_valid), 64'd0);
        chk("rst_hdr", bus.pkt_hdr, 64'd0);
        chk("rst_len", 64'(bus.pkt_len), 64'd0);
        chk("rst_dest", 64'(bus.pkt_dest_err), 64'd0);
        chk("rst_cnt", 64'(pkt_count), 64'd0);
        chk("rst_lerr", 64'(len_err_count), 64'd0);
        chk("rst_ready", 64'(bus.noc2_ready_out), 64'd1);

        // Zero-length packet
        h = mk_hdr(MY_CHIP, 8'd0, 8'h11);
        send_flit(h);
        chk("z_valid", 64'(bus.pkt_valid), 64'd1);
        chk("z_len", 64'(bus.pkt_len), 64'd0);
        chk("z_dest", 64'(bus.pkt_dest_err), 64'd0);
        chk("z_hdr", bus.pkt_hdr, h);
        chk("z_ready_hold", 64'(bus.noc2_ready_out), 64'd0);
        consume();
        chk("z_cnt", 64'(pkt_count), 64'd1);
        chk("z_valid_off", 64'(bus.pkt_valid), 64'd0);
        chk("z_bubble_ready", 64'(bus.noc2_ready_out), 64'd1);

        // Three-flit payload, consumer stalls 5 cycles while the next header waits
        send_flit(mk_hdr(MY_CHIP, 8'd3, 8'h22));
        send_flit(64'hAAAA_0000_0000_000A);
        chk("p3_no_valid_mid", 64'(bus.pkt_valid), 64'd0);
        send_flit(64'hBBBB_0000_0000_000B);
        send_flit(64'hCCCC_0000_0000_000C);
        chk("p3_valid", 64'(bus.pkt_valid), 64'd1);
        chk("p3_len", 64'(bus.pkt_len), 64'd3);
        h = mk_hdr(MY_CHIP, 8'd2, 8'h33);
        bus.noc2_valid_in = 1'b1;
        bus.noc2_data_in  = h;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("p3_hold_ready", 64'(bus.noc2_ready_out), 64'd0);
            chk("p3_hold_valid", 64'(bus.pkt_valid), 64'd1);
            @(negedge clk);
        end
        rd_chk("p3_rd0", 0, 64'hAAAA_0000_0000_000A);
        rd_chk("p3_rd1", 1, 64'hBBBB_0000_0000_000B);
        rd_chk("p3_rd2", 2, 64'hCCCC_0000_0000_000C);
        rd_chk("p3_rd3", 3, 64'd0);
        consume();
        chk("p3_cnt", 64'(pkt_count), 64'd2);
        chk("p3_bubble_ready", 64'(bus.noc2_ready_out), 64'd1);

        // len=2 with throttle between payload flits; the waiting header is taken now
        send_flit(h);
        chk("t_hdr", bus.pkt_hdr, h);
        send_flit(64'h1111_2222_3333_4444);
        bus.throttle      = 1'b1;
        bus.noc2_valid_in = 1'b1;
        bus.noc2_data_in  = 64'h5555_6666_7777_8888;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t_thr_ready", 64'(bus.noc2_ready_out), 64'd0);
            chk("t_thr_valid", 64'(bus.pkt_valid), 64'd0);
            @(negedge clk);
        end
        bus.throttle = 1'b0;
        send_flit(64'h5555_6666_7777_8888);
        chk("t_valid", 64'(bus.pkt_valid), 64'd1);
        chk("t_len", 64'(bus.pkt_len), 64'd2);
        rd_chk("t_rd0", 0, 64'h1111_2222_3333_4444);
        rd_chk("t_rd1", 1, 64'h5555_6666_7777_8888);
        rd_chk("t_rd2", 2, 64'd0);
        consume();
        chk("t_cnt", 64'(pkt_count), 64'd3);

        // Oversize packet: len=12 is swallowed, then a len=1 packet
        send_flit(mk_hdr(MY_CHIP, 8'd12, 8'h44));
        for (int i = 0; i < 12; i++) begin
            send_flit(64'hDEAD_0000_0000_0000 | 64'(i));
            chk("ov_no_valid", 64'(bus.pkt_valid), 64'd0);
        end
        chk("ov_lerr", 64'(len_err_count), 64'd1);
        chk("ov_cnt", 64'(pkt_count), 64'd3);
        chk("ov_ready", 64'(bus.noc2_ready_out), 64'd1);
        send_flit(mk_hdr(MY_CHIP, 8'd1, 8'h55));
        send_flit(64'h0D0D_0D0D_0D0D_0D0D);
        chk("ov_next_valid", 64'(bus.pkt_valid), 64'd1);
        chk("ov_next_len", 64'(bus.pkt_len), 64'd1);
        rd_chk("ov_next_rd0", 0, 64'h0D0D_0D0D_0D0D_0D0D);
        rd_chk("ov_next_rd1", 1, 64'd0);
        consume();
        chk("ov_next_cnt", 64'(pkt_count), 64'd4);

        // Misrouted packet still delivered, flagged
        send_flit(mk_hdr(MY_CHIP + 14'd1, 8'd1, 8'h66));
        send_flit(64'h0E0E_0E0E_0E0E_0E0E);
        chk("de_valid", 64'(bus.pkt_valid), 64'd1);
        chk("de_flag", 64'(bus.pkt_dest_err), 64'd1);
        rd_chk("de_rd0", 0, 64'h0E0E_0E0E_0E0E_0E0E);
        consume();
        chk("de_cnt", 64'(pkt_count), 64'd5);

        // Reset after 2 of 5 payload flits
        send_flit(mk_hdr(MY_CHIP, 8'd5, 8'h77));
        send_flit(64'h0000_0000_0000_0F01);
        send_flit(64'h0000_0000_0000_0F02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_cnt", 64'(pkt_count), 64'd0);
        chk("mr_valid", 64'(bus.pkt_valid), 64'd0);
        chk("mr_lerr", 64'(len_err_count), 64'd0);
        chk("mr_ready", 64'(bus.noc2_ready_out), 64'd1);
        chk("mr_len", 64'(bus.pkt_len), 64'd0);
        @(negedge clk);
        send_flit(mk_hdr(MY_CHIP, 8'd1, 8'h88));
        chk("mr_next_no_valid", 64'(bus.pkt_valid), 64'd0);
        send_flit(64'h0123_4567_89AB_CDEF);
        chk("mr_next_valid", 64'(bus.pkt_valid), 64'd1);
        chk("mr_next_len", 64'(bus.pkt_len), 64'd1);
        rd_chk("mr_next_rd0", 0, 64'h0123_4567_89AB_CDEF);
        consume();
        chk("mr_next_cnt", 64'(pkt_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
